// File: rtl/npc_bpu.sv
// Next-PC unit: registered fetch PC, EX branch comparator and 2-bit BHT predictor.
// Define NPC_BPU_PRED_EN to build the BHT; without it the unit predicts static not-taken.
module npc_bpu #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BHT_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_stall,
  input  logic        if_is_branch,
  input  logic        if_is_jump,
  input  logic [15:0] if_imm16,
  input  logic [25:0] if_imm26,
  output logic [31:0] pc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jr,
  input  logic [2:0]  ex_cmp_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [31:0] ex_pc,
  input  logic [15:0] ex_imm16,
  input  logic        ex_pred_taken,
  output logic        ex_taken,
  output logic [31:0] ex_laddr,
  output logic        flush
);

  localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'd0,
    CMP_BNE  = 3'd1,
    CMP_BLEZ = 3'd2,
    CMP_BGTZ = 3'd3,
    CMP_BLTZ = 3'd4,
    CMP_BGEZ = 3'd5
  } cmp_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_br_target, ex_br_target, jump_target;
  logic        a_neg, a_zero;
  logic        bht_hit;

  assign pc = pc_q;

  assign if_br_target = pc_q  + 32'd4 + {{14{if_imm16[15]}}, if_imm16, 2'b00};
  assign ex_br_target = ex_pc + 32'd4 + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};
  assign jump_target  = {pc_q[31:28], if_imm26, 2'b00};
  assign ex_laddr     = ex_pc + 32'd8;

  // Sign-against-zero compares reduce to the sign bit and a zero detect.
  assign a_neg  = ex_a[31];
  assign a_zero = (ex_a == 32'd0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    ex_taken = 1'b0;
    case (cmp_op_e'(ex_cmp_op))
      CMP_BEQ:  ex_taken = (ex_a == ex_b);
      CMP_BNE:  ex_taken = (ex_a != ex_b);
      CMP_BLEZ: ex_taken = a_neg | a_zero;
      CMP_BGTZ: ex_taken = ~a_neg & ~a_zero;
      CMP_BLTZ: ex_taken = a_neg;
      CMP_BGEZ: ex_taken = ~a_neg;
      default:  ex_taken = 1'b0;
    endcase
  end

  // JR is never predicted, so it always redirects.
  assign flush = ex_valid & (ex_is_jr | (ex_is_branch & (ex_taken != ex_pred_taken)));

`ifdef NPC_BPU_PRED_EN
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx, ex_idx;

  assign if_idx = pc_q[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // IF reads the registered counter, so a same-index update this cycle is not seen yet.
  assign bht_hit = bht_q[if_idx][1];

  always_comb begin
    bht_d = bht_q;
    if (ex_valid && ex_is_branch) begin
      if (ex_taken && (bht_q[ex_idx] != 2'b11)) begin
        bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
      end else if (!ex_taken && (bht_q[ex_idx] != 2'b00)) begin
        bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the BHT is reset entry by entry because the predictor must start weakly not-taken.
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  assign bht_hit = 1'b0;
`endif

  assign pred_taken = if_is_branch & bht_hit;

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (flush) begin
      if (ex_is_jr)      pc_d = ex_a;
      else if (ex_taken) pc_d = ex_br_target;
      else               pc_d = ex_pc + 32'd4;
    end else if (if_stall) begin
      pc_d = pc_q;
    end else if (if_is_jump) begin
      pc_d = jump_target;
    end else if (pred_taken) begin
      pc_d = if_br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_npc_bpu.sv
// Self-checking bench for npc_bpu: directed test-plan steps plus randomized traffic,
// scored against a queue of expectations from an arithmetic reference model.
module tb_npc_bpu;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam int          BHT_DEPTH = 64;
`ifdef NPC_BPU_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_stall, if_is_branch, if_is_jump;
  logic [15:0] if_imm16;
  logic [25:0] if_imm26;
  logic [31:0] pc;
  logic        pred_taken;
  logic        ex_valid, ex_is_branch, ex_is_jr;
  logic [2:0]  ex_cmp_op;
  logic [31:0] ex_a, ex_b, ex_pc;
  logic [15:0] ex_imm16;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic [31:0] ex_laddr;
  logic        flush;

  npc_bpu #(.RESET_PC(RESET_PC), .BHT_DEPTH(BHT_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_stall(if_stall), .if_is_branch(if_is_branch), .if_is_jump(if_is_jump),
    .if_imm16(if_imm16), .if_imm26(if_imm26),
    .pc(pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jr(ex_is_jr),
    .ex_cmp_op(ex_cmp_op), .ex_a(ex_a), .ex_b(ex_b), .ex_pc(ex_pc),
    .ex_imm16(ex_imm16), .ex_pred_taken(ex_pred_taken),
    .ex_taken(ex_taken), .ex_laddr(ex_laddr), .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_stall, if_is_branch, if_is_jump;
    logic [15:0] if_imm16;
    logic [25:0] if_imm26;
    logic        ex_valid, ex_is_branch, ex_is_jr;
    logic [2:0]  ex_cmp_op;
    logic [31:0] ex_a, ex_b, ex_pc;
    logic [15:0] ex_imm16;
    logic        ex_pred_taken;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
    logic        taken;
    logic [31:0] laddr;
    logic        flush;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  int          m_bht[BHT_DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bht_index(input logic [31:0] addr);
    return int'((addr >> 2) % BHT_DEPTH);
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] base, input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return base + 32'd4 + 32'(off);
  endfunction

  function automatic logic cmp_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return sa <= 0;
      3'd3: return sa > 0;
      3'd4: return sa < 0;
      3'd5: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_pc = RESET_PC;
    for (int i = 0; i < BHT_DEPTH; i++) m_bht[i] = 1;
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    e.pc    = m_pc;
    e.pred  = PRED && s.if_is_branch && (m_bht[bht_index(m_pc)] >= 2);
    e.taken = cmp_taken(s.ex_cmp_op, s.ex_a, s.ex_b);
    e.laddr = s.ex_pc + 32'd8;
    e.flush = s.ex_valid && (s.ex_is_jr || (s.ex_is_branch && (e.taken != s.ex_pred_taken)));
    return e;
  endfunction

  function automatic void model_adv(input stim_t s, input exp_t e);
    int k;
    if (e.flush) begin
      if (s.ex_is_jr)   m_pc = s.ex_a;
      else if (e.taken) m_pc = br_target(s.ex_pc, s.ex_imm16);
      else              m_pc = s.ex_pc + 32'd4;
    end else if (s.if_stall) begin
      m_pc = m_pc;
    end else if (s.if_is_jump) begin
      m_pc = {m_pc[31:28], s.if_imm26, 2'b00};
    end else if (e.pred) begin
      m_pc = br_target(m_pc, s.if_imm16);
    end else begin
      m_pc = m_pc + 32'd4;
    end
    if (PRED && s.ex_valid && s.ex_is_branch) begin
      k = bht_index(s.ex_pc);
      if (e.taken) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
      else         m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
    end
  endfunction

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    if_stall      = s.if_stall;
    if_is_branch  = s.if_is_branch;
    if_is_jump    = s.if_is_jump;
    if_imm16      = s.if_imm16;
    if_imm26      = s.if_imm26;
    ex_valid      = s.ex_valid;
    ex_is_branch  = s.ex_is_branch;
    ex_is_jr      = s.ex_is_jr;
    ex_cmp_op     = s.ex_cmp_op;
    ex_a          = s.ex_a;
    ex_b          = s.ex_b;
    ex_pc         = s.ex_pc;
    ex_imm16      = s.ex_imm16;
    ex_pred_taken = s.ex_pred_taken;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(negedge clk);
    apply(s);
    rst_n = 1'b1;
    e = model_out(s);
    exp_q.push_back(e);
    model_adv(s, e);
  endtask

  // Reset asserted in the middle of the low clock phase, away from any edge.
  task automatic reset_mid(input stim_t s);
    exp_t e;
    @(negedge clk);
    apply(s);
    #2;
    rst_n = 1'b0;
    model_reset();
    e = model_out(s);
    exp_q.push_back(e);
  endtask

  function automatic stim_t ex_br(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] epc, input logic [15:0] imm, input logic pt);
    stim_t s;
    s = idle();
    s.ex_valid = 1'b1; s.ex_is_branch = 1'b1; s.ex_cmp_op = op;
    s.ex_a = a; s.ex_b = b; s.ex_pc = epc; s.ex_imm16 = imm; s.ex_pred_taken = pt;
    return s;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.if_stall      = ($urandom_range(0, 3) == 0);
    s.if_is_jump    = ($urandom_range(0, 7) == 0);
    s.if_is_branch  = !s.if_is_jump && ($urandom_range(0, 2) == 0);
    s.if_imm16      = 16'($urandom_range(0, 31) - 16);
    s.if_imm26      = 26'($urandom_range(32'hC00, 32'hC3F));
    s.ex_valid      = ($urandom_range(0, 1) == 1);
    s.ex_is_jr      = ($urandom_range(0, 5) == 0);
    s.ex_is_branch  = !s.ex_is_jr;
    s.ex_cmp_op     = 3'($urandom_range(0, 7));
    s.ex_a          = s.ex_is_jr ? 32'h0000_3000 + 32'($urandom_range(0, 255)) : pick_op();
    s.ex_b          = pick_op();
    s.ex_pc         = 32'h0000_3000 + 32'(4 * $urandom_range(0, 15));
    s.ex_imm16      = 16'($urandom_range(0, 31) - 16);
    s.ex_pred_taken = ($urandom_range(0, 1) == 1);
    return s;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("pred_taken", 32'(pred_taken), 32'(e.pred));
        check("ex_taken", 32'(ex_taken), 32'(e.taken));
        check("ex_laddr", ex_laddr, e.laddr);
        check("flush", 32'(flush), 32'(e.flush));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    model_reset();
    apply(idle());
    rst_n = 1'b0;
    #12;

    // Sequential fetch and stall
    repeat (3) step(idle());
    s = idle(); s.if_stall = 1'b1;
    repeat (2) step(s);
    step(idle());

    // Jump from 3010 to 3100
    s = idle(); s.if_is_jump = 1'b1; s.if_imm26 = 26'h0000C40;
    step(s);

    // BEQ at 3020 resolves taken while predicted not-taken, target 3014
    step(ex_br(3'd0, 32'd5, 32'd5, 32'h0000_3020, 16'hFFFC, 1'b0));
    // Jump to 3020, then fetch it as a branch
    s = idle(); s.if_is_jump = 1'b1; s.if_imm26 = 26'h0000C08;
    step(s);
    s = idle(); s.if_is_branch = 1'b1; s.if_imm16 = 16'hFFFC;
    step(s);

    // Saturation then BNE mispredict with equal operands
    repeat (3) step(ex_br(3'd0, 32'd7, 32'd7, 32'h0000_3020, 16'hFFFC, 1'b1));
    step(ex_br(3'd1, 32'd9, 32'd9, 32'h0000_3020, 16'hFFFC, 1'b1));
    s = idle(); s.if_is_jump = 1'b1; s.if_imm26 = 26'h0000C08;
    step(s);
    s = idle(); s.if_is_branch = 1'b1; s.if_imm16 = 16'h0010;
    step(s);

    // Signed compares
    step(ex_br(3'd4, 32'h8000_0000, 32'd0, 32'h0000_3040, 16'h0004, 1'b1));
    step(ex_br(3'd5, 32'd0, 32'hDEAD_BEEF, 32'h0000_3044, 16'h0004, 1'b1));
    step(ex_br(3'd3, 32'd0, 32'd0, 32'h0000_3048, 16'h0004, 1'b0));
    step(ex_br(3'd2, 32'hFFFF_FFFF, 32'd0, 32'h0000_304C, 16'h0004, 1'b0));
    step(ex_br(3'd6, 32'd1, 32'd1, 32'h0000_3050, 16'h0004, 1'b0));

    // JR under stall
    s = idle(); s.if_stall = 1'b1; s.ex_valid = 1'b1; s.ex_is_jr = 1'b1;
    s.ex_a = 32'h0000_4000; s.ex_pc = 32'h0000_3060;
    step(s);
    s = idle(); s.if_stall = 1'b1;
    step(s);
    // Misaligned JR is loaded unchanged
    s = idle(); s.ex_valid = 1'b1; s.ex_is_jr = 1'b1; s.ex_a = 32'h0000_3003; s.ex_pc = 32'h0000_3064;
    step(s);

    // Training under stall, same-index read/write, then async reset
    s = ex_br(3'd0, 32'd1, 32'd1, 32'h0000_3020, 16'hFFFC, 1'b1);
    s.if_stall = 1'b1;
    repeat (2) step(s);
    s = idle(); s.if_is_jump = 1'b1; s.if_imm26 = 26'h0000C08;
    step(s);
    s = ex_br(3'd1, 32'd1, 32'd1, 32'h0000_3020, 16'hFFFC, 1'b1);
    s.if_is_branch = 1'b1; s.if_imm16 = 16'hFFFC; s.if_stall = 1'b1;
    step(s);
    s = idle(); s.if_is_branch = 1'b1; s.if_imm16 = 16'hFFFC;
    reset_mid(s);
    step(idle());
    s = idle(); s.if_is_jump = 1'b1; s.if_imm26 = 26'h0000C08;
    step(s);
    s = idle(); s.if_is_branch = 1'b1; s.if_imm16 = 16'hFFFC;
    step(s);

    // Randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
      if ($urandom_range(0, 299) == 0) reset_mid(s);
      else                             step(s);
    end

    step(idle());
    repeat (2) @(negedge clk);
    #5;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/npc_bpu.md
# npc_bpu

Parametrised next-PC unit with a registered PC, a generalised branch comparator and a per-index 2-bit branch history table (BHT). It sits between the IF and EX stages of the pipelined MIPS core. In IF it predicts the next fetch address from pre-decoded branch/jump fields. In EX it resolves branches and JR, trains the BHT and redirects fetch on a mispredict.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset.
- BHT_DEPTH, 64, number of BHT entries; power of 2, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_stall  in  1  hold the PC (IF/ID not accepting).
- if_is_branch  in  1  instruction at `pc` is a conditional branch.
- if_is_jump  in  1  instruction at `pc` is J/JAL.
- if_imm16  in  16  branch offset of instruction at `pc`.
- if_imm26  in  26  jump index of instruction at `pc`.
- pc  out  32  current fetch address (registered).
- pred_taken  out  1  prediction for instruction at `pc`; carried down the pipeline.
- ex_valid  in  1  EX holds a valid control-transfer instruction; one-cycle pulse per instruction.
- ex_is_branch  in  1  EX instruction is a conditional branch.
- ex_is_jr  in  1  EX instruction is JR/JALR.
- ex_cmp_op  in  3  compare op: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6/7 never taken.
- ex_a, ex_b  in  32  forwarded rs, rt operands.
- ex_pc  in  32  PC of the EX instruction.
- ex_imm16  in  16  branch offset of the EX instruction.
- ex_pred_taken  in  1  `pred_taken` carried with the EX instruction.
- ex_taken  out  1  comparator result (combinational).
- ex_laddr  out  32  ex_pc + 8, link address (combinational).
- flush  out  1  mispredict; IF/ID and ID/EX must be squashed (combinational).

## Operation
- **Branch target.** Target = base + 4 + (sext(imm16) << 2), mod 2^32. The base is `pc` in IF and `ex_pc` in EX.
- **Jump target.** Target = {pc[31:28], imm26, 2'b00}.
- **Comparator.** BEQ/BNE use a == b. BLEZ/BGTZ/BLTZ/BGEZ compare ex_a, taken as signed, against zero; ex_b is ignored.
- **BHT.** BHT_DEPTH 2-bit saturating counters, indexed by pc[log2(BHT_DEPTH)+1:2].
  - Reset value of every entry: 2'b01 (weakly not-taken).
  - pred_taken = if_is_branch & counter[1].
- **Training.** When ex_valid & ex_is_branch, the counter at ex_pc's index increments if ex_taken, otherwise decrements. It saturates at 0 and 3.
- **Mispredict.** flush = ex_valid & (ex_is_jr | (ex_is_branch & (ex_taken != ex_pred_taken))).
  - JR is always predicted not-taken, so it always flushes.
- **Next PC, by priority:**
  1. flush: ex_is_jr → ex_a; ex_taken → EX branch target; otherwise ex_pc + 4.
  2. if_stall: pc holds.
  3. if_is_jump: jump target.
  4. pred_taken: IF branch target.
  5. Otherwise pc + 4.
- **Flush vs. stall.** A redirect overrides if_stall.
- **Training under stall.** BHT training is independent of if_stall.
- **Simultaneous read and write.** If an IF read and an EX update hit the same index in one cycle, IF sees the old counter value.
- **Misaligned JR.** JR to a misaligned ex_a is loaded unchanged; the unit does not check alignment.

## Timing
- **Reset.** Asynchronous assert. On reset, pc = RESET_PC and all BHT entries = 01. flush, ex_taken and pred_taken follow their inputs.
- **Release.** rst_n is sampled synchronously on release. The first fetch is RESET_PC.
- **Latency.** Prediction and redirect take effect at the next rising edge: zero-bubble predicted-taken, one edge to redirect.
- **Mispredict penalty.** Two squashed slots (IF, ID). The squash is owned by the pipeline registers using `flush`.
- **Training visibility.** A counter update is visible to a fetch on the cycle after the training edge.
- **Reset mid-operation.** BHT and PC reinitialise immediately. No pending redirect survives reset.

## Configuration
- **NPC_BPU_PRED_EN defined:** the BHT is present and behaves as described above.
- **NPC_BPU_PRED_EN undefined:**
  - The BHT is removed; there is no storage and no training.
  - pred_taken is constant 0 (static not-taken).
  - Every taken branch flushes.
  - Comparator, jumps, JR and ports are unchanged.

## Test plan
- **Reset and sequential fetch.** Reset with RESET_PC = 32'h0000_3000, release, no control inputs → pc = 3000, 3004, 3008 on successive edges. Assert if_stall for 2 cycles → pc holds at 300C.
- **Jump.** At pc = 3010, assert if_is_jump with imm26 = 26'h0000C40 → next pc = 32'h0000_3100, flush = 0.
- **Training to taken.** Resolve a BEQ at ex_pc = 3020 with ex_a = ex_b = 5, ex_imm16 = 16'hFFFC, ex_pred_taken = 0 → flush = 1, next pc = 32'h0000_3014. Counter → 10. A later fetch of 3020 with if_is_branch gives pred_taken = 1 and next pc 3014.
- **Saturation and mispredict.** Train the same index taken 3 times → counter stays at 11. Then resolve BNE with equal operands and ex_pred_taken = 1 → flush = 1, next pc = ex_pc + 4, counter = 10.
- **Signed compare and JR.**
  - BLTZ with ex_a = 32'h8000_0000 → ex_taken = 1.
  - BGEZ with ex_a = 0 → ex_taken = 1.
  - BGTZ with ex_a = 0 → ex_taken = 0.
  - JR with ex_a = 32'h0000_4000 while if_stall = 1 → flush = 1, pc = 4000 next edge, ex_laddr = ex_pc + 8.
- **Async reset mid-stream.** Drop rst_n mid-cycle after BHT training → pc = RESET_PC immediately; previously trained index predicts not-taken.
